// File: rtl/int_source_ctrl_if.sv
// Register bus and interrupt handshake between the core and the interrupt source front-end.
// The core side uses the master modport and the front-end uses the slave modport.
interface int_source_ctrl_if #(
  parameter int NUM_SRC = 14
) ();
  logic               reg_we_i;
  logic [3:0]         reg_addr_i;
  logic [31:0]        reg_wdata_i;
  logic [31:0]        reg_rdata_o;
  logic               int_ack_i;
  logic               int_done_i;
  logic [NUM_SRC-1:0] int_flag_o;
  logic [3:0]         int_id_o;

  modport master (
    output reg_we_i, reg_addr_i, reg_wdata_i, int_ack_i, int_done_i,
    input  reg_rdata_o, int_flag_o, int_id_o
  );

  modport slave (
    input  reg_we_i, reg_addr_i, reg_wdata_i, int_ack_i, int_done_i,
    output reg_rdata_o, int_flag_o, int_id_o
  );
endinterface

// File: rtl/int_source_ctrl.sv
// Interrupt source front-end: synchronises external lines, latches level/edge pending bits,
// and presents one fixed-priority one-hot request to the core, held until ack and blocked until mret.
module int_source_ctrl #(
  parameter int NUM_SRC     = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  int_source_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_EDGESEL = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_CLAIM   = 2'd3;

  localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);
  localparam logic [3:0]         NO_ID    = 4'hF;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s, s_d;
  logic [NUM_SRC-1:0] enable, edge_sel, pending, pend_nxt;
  logic [NUM_SRC-1:0] rise, w1c, ack_clr, mode_chg, edge_nxt, eligible;
  logic [1:0]         st;
  logic [3:0]         id, win_id;
  logic [1:0]         waddr;
  logic               unused_bits;

  assign waddr       = bus.reg_addr_i[3:2];
  assign unused_bits = ^{bus.reg_addr_i[1:0], bus.reg_wdata_i[31:NUM_SRC]};

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_d;
  assign eligible = pending & enable;

  assign w1c      = (bus.reg_we_i && waddr == A_PENDING) ? bus.reg_wdata_i[NUM_SRC-1:0] : '0;
  assign mode_chg = (bus.reg_we_i && waddr == A_EDGESEL)
                  ? (bus.reg_wdata_i[NUM_SRC-1:0] ^ edge_sel) : '0;
  assign ack_clr  = bus.int_flag_o & {NUM_SRC{bus.int_ack_i}};

  // A fresh edge beats any clear landing in the same cycle; a mode change discards the bit outright.
  assign edge_nxt = (pending & ~(w1c | ack_clr)) | rise;
  assign pend_nxt = ((edge_sel & edge_nxt) | (~edge_sel & s)) & ~mode_chg;

  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    win_id = NO_ID;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 4'(i);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d      <= '0;
      enable   <= '0;
      edge_sel <= '0;
      pending  <= '0;
      st       <= ST_IDLE;
      id       <= NO_ID;
    end else begin
      sync_q[0] <= src_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d     <= s;
      pending <= pend_nxt;

      if (bus.reg_we_i && waddr == A_ENABLE)  enable   <= bus.reg_wdata_i[NUM_SRC-1:0];
      if (bus.reg_we_i && waddr == A_EDGESEL) edge_sel <= bus.reg_wdata_i[NUM_SRC-1:0];

      case (st)
        ST_IDLE: begin
          if (|eligible) begin
            st <= ST_PRESENT;
            id <= win_id;
          end
        end
        ST_PRESENT: begin
          if (bus.int_ack_i) begin
            st <= ST_SERVICE;
          end else if (!(|(eligible & bus.int_flag_o))) begin
            st <= ST_IDLE;
            id <= NO_ID;
          end
        end
        ST_SERVICE: begin
          if (bus.int_done_i) begin
            st <= ST_IDLE;
            id <= NO_ID;
          end
        end
        default: begin
          st <= ST_IDLE;
          id <= NO_ID;
        end
      endcase
    end
  end

  assign bus.int_flag_o = (st == ST_PRESENT) ? (ONE_HOT0 << id) : '0;
  assign bus.int_id_o   = id;

  always_comb begin
    bus.reg_rdata_o = '0;
    case (waddr)
      A_ENABLE:  bus.reg_rdata_o = {{(32-NUM_SRC){1'b0}}, enable};
      A_EDGESEL: bus.reg_rdata_o = {{(32-NUM_SRC){1'b0}}, edge_sel};
      A_PENDING: bus.reg_rdata_o = {{(32-NUM_SRC){1'b0}}, pending};
      A_CLAIM:   bus.reg_rdata_o = {28'b0, (st == ST_IDLE) ? NO_ID : id};
      default:   bus.reg_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_int_source_ctrl.sv
// Directed bench for int_source_ctrl: a register vector table followed by hand-written
// sequences for capture latency, priority, level re-present, W1C collision and reset.
module tb_int_source_ctrl;
  localparam int NUM_SRC = 14;

  localparam logic [3:0] R_ENABLE  = 4'h0;
  localparam logic [3:0] R_EDGESEL = 4'h4;
  localparam logic [3:0] R_PENDING = 4'h8;
  localparam logic [3:0] R_CLAIM   = 4'hC;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] src_i;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  int_source_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

  int_source_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .src_i (src_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    bus.reg_we_i    = 1'b1;
    bus.reg_addr_i  = addr;
    bus.reg_wdata_i = data;
    tick();
    bus.reg_we_i    = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    bus.reg_addr_i = addr;
    #1;
    check(name, bus.reg_rdata_o, exp);
  endtask

  task automatic pulse_ack();
    bus.int_ack_i = 1'b1;
    tick();
    bus.int_ack_i = 1'b0;
  endtask

  task automatic pulse_done();
    bus.int_done_i = 1'b1;
    tick();
    bus.int_done_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"rst_enable",     1'b0, R_ENABLE,  32'h0,        R_ENABLE,  32'h0};
    vecs[1]  = '{"rst_edgesel",    1'b0, R_ENABLE,  32'h0,        R_EDGESEL, 32'h0};
    vecs[2]  = '{"rst_pending",    1'b0, R_ENABLE,  32'h0,        R_PENDING, 32'h0};
    vecs[3]  = '{"rst_claim",      1'b0, R_ENABLE,  32'h0,        R_CLAIM,   32'hF};
    vecs[4]  = '{"enable_mask",    1'b1, R_ENABLE,  32'hFFFF_FFFF, R_ENABLE, 32'h3FFF};
    vecs[5]  = '{"edgesel_rw",     1'b1, R_EDGESEL, 32'h0000_1234, R_EDGESEL, 32'h1234};
    vecs[6]  = '{"claim_ro",       1'b1, R_CLAIM,   32'h0000_0005, R_CLAIM,  32'hF};
    vecs[7]  = '{"addr_low_ign",   1'b1, 4'h1,      32'h0000_00AA, R_ENABLE, 32'hAA};
    vecs[8]  = '{"w1c_empty",      1'b1, R_PENDING, 32'h0000_FFFF, R_PENDING, 32'h0};
    vecs[9]  = '{"enable_clear",   1'b1, R_ENABLE,  32'h0,        R_ENABLE,  32'h0};
    vecs[10] = '{"edgesel_clear",  1'b1, R_EDGESEL, 32'h0,        R_EDGESEL, 32'h0};

    rst             = 1'b1;
    src_i           = '0;
    bus.reg_we_i    = 1'b0;
    bus.reg_addr_i  = 4'h0;
    bus.reg_wdata_i = 32'h0;
    bus.int_ack_i   = 1'b0;
    bus.int_done_i  = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_flag", 32'(bus.int_flag_o), 32'h0);
    check("rst_id",   32'(bus.int_id_o),   32'hF);

    // Register-level vectors
    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      check_reg(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end

    // Edge capture latency: sampled at edge N, presented at N+3
    wr(R_ENABLE,  32'h1);
    wr(R_EDGESEL, 32'h1);
    src_i[0] = 1'b1;
    tick();
    src_i[0] = 1'b0;
    tick(2);
    check("edge_not_yet", 32'(bus.int_flag_o), 32'h0);
    tick();
    check("edge_flag", 32'(bus.int_flag_o), 32'h1);
    check_reg("edge_claim", R_CLAIM, 32'h0);
    check_reg("edge_pend", R_PENDING, 32'h1);
    pulse_ack();
    check("ack_flag_drop", 32'(bus.int_flag_o), 32'h0);
    check_reg("ack_pend_clr", R_PENDING, 32'h0);
    check_reg("service_claim", R_CLAIM, 32'h0);
    pulse_done();
    check_reg("done_claim", R_CLAIM, 32'hF);
    check("done_id", 32'(bus.int_id_o), 32'hF);

    // Spurious ack in IDLE, then priority with a spurious done in PRESENT
    pulse_ack();
    check("ack_idle_flag", 32'(bus.int_flag_o), 32'h0);
    check_reg("ack_idle_claim", R_CLAIM, 32'hF);
    wr(R_ENABLE,  32'h3FFF);
    wr(R_EDGESEL, 32'h3FFF);
    src_i[9] = 1'b1;
    src_i[3] = 1'b1;
    tick();
    src_i = '0;
    tick(3);
    check("prio_flag", 32'(bus.int_flag_o), 32'h0008);
    check("prio_id",   32'(bus.int_id_o),   32'h3);
    pulse_done();
    check("done_in_present", 32'(bus.int_flag_o), 32'h0008);
    pulse_ack();
    check("prio_ack_flag", 32'(bus.int_flag_o), 32'h0);
    pulse_done();
    check("prio_gap", 32'(bus.int_flag_o), 32'h0);
    tick();
    check("prio_next", 32'(bus.int_flag_o), 32'h0200);
    check("prio_next_id", 32'(bus.int_id_o), 32'h9);
    pulse_ack();
    pulse_done();
    check_reg("prio_pend_empty", R_PENDING, 32'h0);

    // Level source re-presents after done, then withdraws when dropped
    wr(R_EDGESEL, 32'h0);
    src_i[5] = 1'b1;
    tick(4);
    check("lvl_flag", 32'(bus.int_flag_o), 32'h0020);
    pulse_ack();
    check("lvl_ack", 32'(bus.int_flag_o), 32'h0);
    pulse_done();
    check("lvl_gap", 32'(bus.int_flag_o), 32'h0);
    tick();
    check("lvl_represent", 32'(bus.int_flag_o), 32'h0020);
    src_i[5] = 1'b0;
    tick(3);
    check("lvl_hold", 32'(bus.int_flag_o), 32'h0020);
    tick();
    check("lvl_withdraw", 32'(bus.int_flag_o), 32'h0);
    check_reg("lvl_withdraw_claim", R_CLAIM, 32'hF);

    // W1C behaviour and same-cycle collision with a new edge on bit 2
    wr(R_ENABLE,  32'h0);
    wr(R_EDGESEL, 32'h4);
    src_i[2] = 1'b1;
    tick();
    src_i[2] = 1'b0;
    tick(3);
    check_reg("w1c_setup", R_PENDING, 32'h4);
    wr(R_PENDING, 32'h4);
    check_reg("w1c_clear", R_PENDING, 32'h0);
    src_i[2] = 1'b1;
    tick(2);
    wr(R_PENDING, 32'h4);
    check_reg("w1c_collide", R_PENDING, 32'h4);
    src_i[2] = 1'b0;
    tick(3);
    check_reg("edge_hold", R_PENDING, 32'h4);
    wr(R_EDGESEL, 32'h0);
    check_reg("mode_discard", R_PENDING, 32'h0);

    // Reset while in SERVICE
    wr(R_ENABLE,  32'h1);
    wr(R_EDGESEL, 32'h1);
    src_i[0] = 1'b1;
    tick();
    src_i[0] = 1'b0;
    tick(3);
    check("pre_rst_flag", 32'(bus.int_flag_o), 32'h1);
    pulse_ack();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_flag", 32'(bus.int_flag_o), 32'h0);
    check("mid_rst_id",   32'(bus.int_id_o),   32'hF);
    check_reg("mid_rst_enable",  R_ENABLE,  32'h0);
    check_reg("mid_rst_edgesel", R_EDGESEL, 32'h0);
    check_reg("mid_rst_pending", R_PENDING, 32'h0);
    check_reg("mid_rst_claim",   R_CLAIM,   32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
